// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// multiply (shift-add) and divide (restoring) behind a start/ready/valid handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       alu_src,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             branch_taken,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is accepted on a rising edge where start=1 and
  // ready=1; out_valid is high for exactly one cycle when outputs update.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] F_BRANCH = 4'd8;
  localparam logic [3:0] F_SUB    = 4'd9;
  localparam logic [3:0] F_BGE    = 4'd10;
  localparam logic [3:0] F_MUL    = 4'd11;
  localparam logic [3:0] F_MULHU  = 4'd12;
  localparam logic [3:0] F_DIVU   = 4'd13;
  localparam logic [3:0] F_REMU   = 4'd14;
  localparam logic [3:0] F_SLTU   = 4'd15;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [3:0]         func_q, func_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d;
  logic               br_q, br_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic               lt;
  logic               accept;
  logic               is_multi;
  logic               is_div_q;

  logic [WIDTH-1:0]   sc_result;
  logic               sc_c, sc_br, sc_dbz;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mc_result;
  logic               mc_c;

  assign opb      = (alu_src == 2'b01 || alu_src == 2'b10) ? imm : b;
  assign sum      = {1'b0, a} + {1'b0, opb};
  assign diff     = a - opb;
  assign lt       = (a < opb);
  assign ready    = (state_q != CALC);
  assign accept   = start && ready;
  assign is_div_q = (func_q == F_DIVU) || (func_q == F_REMU);

  // Divide by zero short-circuits to a single-cycle completion.
  always_comb begin
    is_multi = 1'b0;
    if (func == F_MUL || func == F_MULHU)
      is_multi = 1'b1;
    else if ((func == F_DIVU || func == F_REMU) && opb != '0)
      is_multi = 1'b1;
  end

  always_comb begin
    sc_result = '0;
    sc_c      = 1'b0;
    sc_br     = 1'b0;
    sc_dbz    = 1'b0;
    case (func)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        sc_result = sum[WIDTH-1:0];
        sc_c      = sum[WIDTH];
      end
      4'd4: sc_result = opb;
      4'd5: begin
        sc_result = opb;
        sc_br     = 1'b1;
      end
      4'd6: sc_result = a | opb;
      4'd7: sc_result = a & opb;
      F_BRANCH: begin
        sc_result = diff;
        sc_br     = (diff == '0);
      end
      F_SUB: begin
        sc_result = diff;
        sc_c      = lt;
      end
      // BGE deliberately compares against the raw b port, not the selected operand.
      F_BGE: sc_br = (a >= b);
      F_DIVU: begin
        sc_result = '1;
        sc_dbz    = 1'b1;
      end
      F_REMU: begin
        sc_result = a;
        sc_dbz    = 1'b1;
      end
      F_SLTU: sc_result = {{(WIDTH-1){1'b0}}, lt};
      default: ;
    endcase
  end

  // Multiply: acc = {partial high, remaining multiplier}, shifting right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifting left.
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_rem  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
  assign div_next = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

  assign acc_step = is_div_q ? div_next : mul_next;

  always_comb begin
    mc_result = '0;
    mc_c      = 1'b0;
    case (func_q)
      F_MUL: begin
        mc_result = acc_step[WIDTH-1:0];
        mc_c      = (acc_step[2*WIDTH-1:WIDTH] != '0);
      end
      F_MULHU: mc_result = acc_step[2*WIDTH-1:WIDTH];
      F_DIVU:  mc_result = acc_step[WIDTH-1:0];
      F_REMU:  mc_result = acc_step[2*WIDTH-1:WIDTH];
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    func_d   = func_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_d      = c_q;
    br_d     = br_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          func_d = func;
          a_d    = a;
          b_d    = opb;
          if (is_multi) begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH);
            acc_d   = (func == F_DIVU || func == F_REMU) ? {{WIDTH{1'b0}}, a}
                                                         : {{WIDTH{1'b0}}, opb};
          end else begin
            state_d  = DONE;
            result_d = sc_result;
            c_d      = sc_c;
            br_d     = sc_br;
            dbz_d    = sc_dbz;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = mc_result;
          c_d      = mc_c;
          br_d     = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      br_q     <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      func_q   <= func_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_q      <= c_d;
      br_q     <= br_d;
      dbz_q    <= dbz_d;
    end
  end

  assign out_valid    = (state_q == DONE);
  assign result       = result_q;
  assign c_out        = c_q;
  assign branch_taken = br_q;
  assign div_by_zero  = dbz_q;
  assign dbg_state    = state_q;

endmodule
